// File: rtl/scan_pkg.sv
// scan_pkg: shared types and constants for the scan_counter4 slice.
//   scan_state_t : scan FSM states (IDLE, SHOW, BLANK)
//   scan_idx_t   : 2-bit select index, {vystupB, vystupA}
//   IDX_FIRST / IDX_LAST : ends of the index range, used for wrap detection
//   idx_step     : modulo-4 index advance in either direction
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  typedef logic [1:0] scan_idx_t;

  localparam scan_idx_t IDX_FIRST = 2'd0;
  localparam scan_idx_t IDX_LAST  = 2'd3;

  // 2-bit arithmetic gives the modulo-4 wrap for free.
  function automatic scan_idx_t idx_step(input scan_idx_t idx, input logic down);
    return down ? scan_idx_t'(idx - 2'd1) : scan_idx_t'(idx + 2'd1);
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: CW-bit up-counter with a programmable terminal count.
// Shared by the SHOW and BLANK phases; the caller switches limit per phase.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear to 0 (wins over en)
//   en       : count enable; at terminal count the counter restarts at 0
//   limit    : terminal-count value
//   tc       : high while the count equals limit
module scan_prescaler #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] limit,
  output logic          tc
);

  logic [CW-1:0] cnt;

  assign tc = (cnt == limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scan_counter4.sv
// scan_counter4: 2-bit select generator for the 1-of-4 decoder, used for
// display digit scanning and round-robin row/lamp selection.
// Optional build macro SCAN_BLANK_EN inserts a BLANK gap (vystupEN low,
// index held) between slots; without it the index advances straight from
// the end of one SHOW slot into the next.
//   clk, rst : clock, async active-high reset
//   en       : scan enable (level)
//   dir      : 0 = count up, 1 = count down (sampled on advance edges only)
//   vystupA  : select LSB   vystupB : select MSB
//   vystupEN : high while the current select is being shown
//   wrap     : one-cycle pulse on the cycle the wrapped index first appears
//
// state | meaning
// IDLE  | disabled, prescaler cleared, index held, vystupEN low
// SHOW  | index displayed for DIV cycles, vystupEN high
// BLANK | gap of BLANK cycles, old index held, vystupEN low (SCAN_BLANK_EN)
module scan_counter4
  import scan_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic dir,
  output logic vystupA,
  output logic vystupB,
  output logic vystupEN,
  output logic wrap
);

  localparam int CW = $clog2(DIV);

  if (DIV < 2) begin : g_bad_div
    $error("scan_counter4: DIV must be >= 2");
  end
`ifdef SCAN_BLANK_EN
  if (BLANK < 1 || BLANK >= DIV) begin : g_bad_blank
    $error("scan_counter4: BLANK must satisfy 1 <= BLANK < DIV");
  end
`endif

  localparam logic [CW-1:0] LIM_SHOW  = CW'(DIV - 1);
  // Without SCAN_BLANK_EN the FSM never reaches BLANK, so this limit is dead.
  localparam logic [CW-1:0] LIM_BLANK = CW'(BLANK - 1);

  scan_state_t   state, state_nxt;
  scan_idx_t     idx, idx_nxt, adv_idx;
  logic          en_nxt, wrap_nxt, adv_wrap;
  logic          p_clr, p_en, p_tc;
  logic [CW-1:0] p_limit;

  assign p_limit  = (state == BLANK) ? LIM_BLANK : LIM_SHOW;
  assign adv_idx  = idx_step(idx, dir);
  assign adv_wrap = dir ? (idx == IDX_FIRST) : (idx == IDX_LAST);

  scan_prescaler #(.CW(CW)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .clr   (p_clr),
    .en    (p_en),
    .limit (p_limit),
    .tc    (p_tc)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    en_nxt    = 1'b0;
    wrap_nxt  = 1'b0;
    p_clr     = 1'b0;
    p_en      = 1'b0;
    case (state)
      IDLE: begin
        p_clr = 1'b1;
        if (en) begin
          state_nxt = SHOW;
          en_nxt    = 1'b1;
        end
      end
      SHOW: begin
        if (!en) begin
          state_nxt = IDLE;
          p_clr     = 1'b1;
        end else begin
          p_en   = 1'b1;
          en_nxt = 1'b1;
          if (p_tc) begin
`ifdef SCAN_BLANK_EN
            state_nxt = BLANK;
            en_nxt    = 1'b0;
`else
            idx_nxt  = adv_idx;
            wrap_nxt = adv_wrap;
`endif
          end
        end
      end
`ifdef SCAN_BLANK_EN
      BLANK: begin
        if (!en) begin
          state_nxt = IDLE;
          p_clr     = 1'b1;
        end else begin
          p_en = 1'b1;
          if (p_tc) begin
            // New index and vystupEN rise together on this edge.
            state_nxt = SHOW;
            en_nxt    = 1'b1;
            idx_nxt   = adv_idx;
            wrap_nxt  = adv_wrap;
          end
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        p_clr     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= IDX_FIRST;
      vystupEN <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      vystupEN <= en_nxt;
      wrap     <= wrap_nxt;
    end
  end

  assign vystupA = idx[0];
  assign vystupB = idx[1];

endmodule

// File: tb/tb_scan_counter4.sv
// Testbench for scan_counter4. Builds with or without SCAN_BLANK_EN.
module tb_scan_counter4;

`ifdef SCAN_BLANK_EN
  localparam int DIV_T = 4;
  localparam int BLANK_T = 2;
  localparam int GAP = 2;
`else
  localparam int DIV_T = 3;
  localparam int BLANK_T = 2;
  localparam int GAP = 0;
`endif
  localparam int P = DIV_T + GAP;   // slot period

  logic clk, rst, en, dir;
  logic vystupA, vystupB, vystupEN, wrap;

  scan_counter4 #(.DIV(DIV_T), .BLANK(BLANK_T)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .vystupA  (vystupA),
    .vystupB  (vystupB),
    .vystupEN (vystupEN),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: active flag, position within the current slot period,
  // index as an integer 0..3, and the wrap flag of the presented cycle.
  bit m_active;
  int m_pos;
  int m_idx;
  bit m_wrap;

  typedef struct {
    logic en;
    logic dir;
    logic [1:0] idx;
    logic sen;
    logic wrp;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic e, logic d, int i, bit s, bit w);
    vec_t v;
    v.en = e; v.dir = d; v.idx = 2'(i); v.sen = s; v.wrp = w;
    return v;
  endfunction

  task automatic model_reset();
    m_active = 0; m_pos = 0; m_idx = 0; m_wrap = 0;
  endtask

  function automatic logic [3:0] model_vec();
    bit s;
    s = m_active && (m_pos < DIV_T);
    return {2'(m_idx), s, m_wrap};
  endfunction

  // Advance the model with the inputs currently applied, then let the DUT
  // take the same clock edge and settle.
  task automatic tick();
    int old;
    m_wrap = 0;
    if (!m_active) begin
      if (en) begin m_active = 1; m_pos = 0; end
    end else if (!en) begin
      m_active = 0; m_pos = 0;
    end else begin
      m_pos++;
      if (m_pos == P) begin
        m_pos = 0;
        old = m_idx;
        m_idx = dir ? (m_idx + 3) % 4 : (m_idx + 1) % 4;
        m_wrap = dir ? (old == 0) : (old == 3);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [3:0] exp);
    logic [3:0] act;
    act = {vystupB, vystupA, vystupEN, wrap};
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: {B,A,EN,wrap} got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_true(string nm, bit c);
    n_chk++;
    if (!c) begin
      n_err++;
      $display("FAIL %s: condition false at %0t", nm, $time);
    end
  endtask

  task automatic tick_m(string nm);
    tick();
    chk(nm, model_vec());
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Up run from reset covering one full 4-slot cycle, then disable.
    for (int k = 0; k <= 4 * P; k++)
      tbl.push_back(mk(1'b1, 1'b0, (k / P) % 4, (k % P) < DIV_T, k == 4 * P));
    tbl.push_back(mk(1'b0, 1'b0, 0, 1'b0, 1'b0));
    // Down run from index 0: first advance is the 0->3 wrap.
    for (int k = 0; k <= P; k++)
      tbl.push_back(mk(1'b1, 1'b1, (4 - (k / P)) % 4, (k % P) < DIV_T, k == P));
    tbl.push_back(mk(1'b0, 1'b1, 3, 1'b0, 1'b0));

    rst = 1'b1; en = 1'b0; dir = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    tick_m("idle_after_reset");

    foreach (tbl[i]) begin
      en = tbl[i].en;
      dir = tbl[i].dir;
      tick();
      chk($sformatf("tbl[%0d]", i), {tbl[i].idx, tbl[i].sen, tbl[i].wrp});
    end

    // Direction toggled mid-slot only matters at the advance edge.
    en = 1'b1; dir = 1'b1;
    tick_m("dir_start");
    dir = 1'b0;
    for (int i = 0; i < 50 && m_pos != P - 1; i++) tick_m("dir_mid");
    chk_true("dir_seek", m_pos == P - 1);
    dir = 1'b1;
    tick_m("dir_adv");
    chk("dir_adv_down", {2'd2, 1'b1, 1'b0});
    dir = 1'b0;
    for (int i = 0; i < P; i++) tick_m("dir_up_slot");
    chk("dir_adv_up", {2'd3, 1'b1, 1'b0});

    // Disable on the second SHOW cycle at index 2, then resume.
    for (int i = 0; i < 200 && !(m_idx == 2 && m_pos == 1); i++) tick_m("dis_seek");
    chk_true("dis_seek", m_idx == 2 && m_pos == 1);
    en = 1'b0;
    tick_m("dis_drop");
    chk("dis_hold", {2'd2, 1'b0, 1'b0});
    tick_m("dis_idle");
    en = 1'b1;
    for (int i = 0; i < P; i++) tick_m("dis_resume");
    chk("dis_full_slot", {2'd2, (GAP == 0), 1'b0});
    tick_m("dis_next");
    chk("dis_adv", {2'd3, 1'b1, 1'b0});

    // Asynchronous reset while index is 3 (in BLANK when it exists).
    for (int i = 0; i < 50 && m_pos != ((GAP > 0) ? DIV_T : 1); i++) tick_m("rst_seek");
    chk_true("rst_seek", m_idx == 3 && m_pos == ((GAP > 0) ? DIV_T : 1));
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", 4'b0000);
    en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held", 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    tick_m("rst_reenable");

    // Randomized run against the model.
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      tick_m("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/scan_counter4.md
Name: scan_counter4

Overview:
- Upstream driver for the 1-of-4 decoder block. Produces the 2-bit select (vystupA = LSB, vystupB = MSB) that steps through decoder outputs 1..4.
- Used for multiplexed 4-digit display scanning and round-robin lamp/row selection on the Cyclone board designs.
- Prescales the system clock, optionally inserts a blanking gap between slots, and supports up/down direction and enable.

Parameters:
- DIV, 50000, clock cycles per active (SHOW) slot; legal range DIV >= 2.
- BLANK, 500, clock cycles of blanking between slots; legal range 1 <= BLANK < DIV. Used only when SCAN_BLANK_EN is defined.
- CW, $clog2(DIV), prescaler counter width (derived; not to be overridden).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable; level-sensitive.
- dir  in  1  0 = count up (0→1→2→3→0), 1 = count down (0→3→2→1→0).
- vystupA  out  1  select LSB; connects to the decoder's vstupA.
- vystupB  out  1  select MSB; connects to the decoder's vstupB.
- vystupEN  out  1  slot-active strobe; 1 while the current select is being shown.
- wrap  out  1  one-cycle pulse when the index wraps (3→0 going up, 0→3 going down).

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-high (rst). All outputs are registered.
- Reset values: index = 0 (vystupA = 0, vystupB = 0), state = IDLE, prescaler = 0, vystupEN = 0, wrap = 0.
- Index mapping, matching the decoder: index {vystupB, vystupA} = 00/01/10/11 selects vystup1/2/3/4 respectively.
- IDLE:
  - vystupEN = 0, prescaler held at 0, index held.
  - en = 1 → SHOW on the next edge; vystupEN = 1 from that edge.
- SHOW:
  - vystupEN = 1; prescaler counts 0..DIV-1.
  - At terminal count DIV-1: go to BLANK (SCAN_BLANK_EN defined), or advance the index and restart SHOW (SCAN_BLANK_EN undefined).
- BLANK:
  - vystupEN = 0 and the index is held at the old value.
  - After BLANK cycles: advance the index, return to SHOW with prescaler = 0. vystupEN rises on the same edge the new index appears.
- Index advance:
  - dir is sampled on the advance edge only; changing dir mid-slot has no effect until the next advance.
  - Index arithmetic is 2-bit modulo-4.
  - wrap = 1 for exactly the cycle in which the wrapped index is first presented.
- Slot period: DIV + BLANK cycles (blank enabled); DIV cycles (blank disabled). The full sequence repeats every 4 slot periods.
- en deasserted in SHOW or BLANK: next edge → IDLE, vystupEN = 0, prescaler cleared, index held, no advance and no wrap. Re-enable resumes at the held index with a full fresh SHOW slot.
- en and terminal count on the same cycle with en = 0: en wins (no advance).
- rst mid-slot: immediate return to reset values regardless of state.
- Parameter violations (DIV < 2, or BLANK outside 1..DIV-1 with SCAN_BLANK_EN): elaboration-time error.

Optional Feature:
- Macro: SCAN_BLANK_EN.
- Defined: the BLANK state and BLANK counter are compiled in, giving an anti-ghosting gap with vystupEN low between slots.
- Undefined: no BLANK state exists; the index advances directly at the end of SHOW. vystupEN stays 1 whenever en has been high for at least one cycle. The BLANK parameter is ignored.

Decomposition:
- Package scan_pkg holds:
  - typedef scan_state_t {IDLE, SHOW, BLANK};
  - typedef scan_idx_t as logic [1:0];
  - constants IDX_FIRST = 2'd0 and IDX_LAST = 2'd3.
- One sub-module, scan_prescaler: a CW-bit counter with clear, enable and a programmable terminal-count output. It is instantiated once and reused for both SHOW (limit DIV-1) and BLANK (limit BLANK-1) timing.

Test Plan (DIV = 4, BLANK = 2 unless stated):
- Reset and enable: rst pulse, then en = 1, dir = 0 → vystupEN rises 1 cycle after en. Index sequence 0,1,2,3,0 with 6-cycle slots and vystupEN low for 2 cycles before each change. wrap is high exactly on the cycle index returns to 0.
- Down count: dir = 1 from reset → sequence 0,3,2,1,0; wrap pulses on 0→3. Toggling dir mid-slot changes direction only at the next advance.
- Disable mid-slot: drop en at cycle 2 of SHOW with index = 2 → vystupEN = 0 next cycle, index stays 2. Re-enable → full 4-cycle SHOW at index 2 before advancing to 3.
- Asynchronous reset during BLANK with index = 3: outputs go to 0 immediately without waiting for a clock edge, and wrap is not pulsed.
- Build without SCAN_BLANK_EN, DIV = 3: index advances every 3 cycles, vystupEN constantly 1 while en = 1, wrap every 12 cycles.
- Parameter check: DIV = 1, or BLANK = 4 with DIV = 4 and SCAN_BLANK_EN defined → elaboration fails.
